// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the /10 divider monitor.
// State encoding, fault codes and the phase tolerance check.
package div_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_MEASURE,
    ST_LOCKED,
    ST_FAULT
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_HIGH  = 2'b01;
  localparam logic [1:0] FC_LOW   = 2'b10;
  localparam logic [1:0] FC_STUCK = 2'b11;

  // Plain ints keep the difference from wrapping.
  function automatic logic phase_ok(
    input int len,
    input int exp_len,
    input int tol
  );
    if (len >= exp_len) return (len - exp_len) <= tol;
    return (exp_len - len) <= tol;
  endfunction

endpackage

// File: rtl/div_phase_counter.sv
// Edge detector and saturating phase-length counter for div_clk,
// sampled directly in the clk_in domain.
module div_phase_counter
  import div_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 20
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             div_clk,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] phase_len,
  output logic             timeout
);

  logic             div_q;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] run_d;
  logic             any_edge;

  assign rise     = div_clk & ~div_q;
  assign fall     = ~div_clk & div_q;
  assign any_edge = rise | fall;

  always_comb begin
    run_d = run_q;
    if (any_edge) begin
      run_d = CNT_W'(1);
    end else if (~&run_q) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_q <= 1'b0;
      run_q <= '0;
    end else begin
      div_q <= div_clk;
      run_q <= run_d;
    end
  end

  assign phase_len = run_q;
  assign timeout   = ~any_edge & (run_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/div_clk_monitor.sv
// Lock/fault monitor for the /10 divider output: measures each phase,
// locks after LOCK_COUNT good periods, latches a sticky fault code.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int EXP_HIGH   = 5,
  parameter int EXP_LOW    = 5,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 20,
  parameter int CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_clk,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  logic             rise;
  logic             fall;
  logic             tmo;
  logic [CNT_W-1:0] len;

  div_phase_counter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_cnt (
    .clk_in   (clk_in),
    .reset    (reset),
    .div_clk  (div_clk),
    .rise     (rise),
    .fall     (fall),
    .phase_len(len),
    .timeout  (tmo)
  );

  state_e           state_q, state_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic             have_q, have_d;
  logic             hgood_q, hgood_d;
  logic [CNT_W-1:0] hlen_q, hlen_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             meas_q, meas_d;
  logic             lock_q, fault_q;
  logic [1:0]       code_q, code_d;
  logic             ok_h, ok_l, viol;
  logic [1:0]       vcode;

  assign ok_h     = phase_ok(int'(len), EXP_HIGH, TOL);
  assign ok_l     = phase_ok(int'(len), EXP_LOW, TOL);
  assign good_inc = good_q + 1'b1;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    have_d  = have_q;
    hgood_d = hgood_q;
    hlen_d  = hlen_q;
    high_d  = high_q;
    low_d   = low_q;
    meas_d  = 1'b0;
    code_d  = code_q;
    viol    = 1'b0;
    vcode   = FC_NONE;

    unique case (state_q)
      ST_IDLE: begin
        good_d = '0;
        have_d = 1'b0;
        if (enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        good_d = '0;
        have_d = 1'b0;
        if (rise | fall) begin
          state_d = ST_MEASURE;
        end else if (tmo) begin
          viol  = 1'b1;
          vcode = FC_STUCK;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (fall) begin
          hlen_d  = len;
          hgood_d = ok_h;
          have_d  = 1'b1;
          if (state_q == ST_LOCKED && !ok_h) begin
            viol  = 1'b1;
            vcode = FC_HIGH;
          end
        end else if (rise) begin
          have_d = 1'b0;
          if (have_q) begin
            meas_d = 1'b1;
            high_d = hlen_q;
            low_d  = len;
            if (state_q == ST_MEASURE) begin
              if (hgood_q && ok_l) begin
                good_d = good_inc;
                if (good_inc == GW'(LOCK_COUNT)) state_d = ST_LOCKED;
              end else begin
                good_d = '0;
              end
            end
          end
          if (state_q == ST_LOCKED && !ok_l) begin
            viol  = 1'b1;
            vcode = FC_LOW;
          end
        end else if (tmo) begin
          viol  = 1'b1;
          vcode = FC_STUCK;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_SYNC;
          good_d  = '0;
          code_d  = FC_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear arriving with a violation wins: resync instead of faulting.
    if (viol) begin
      good_d = '0;
      if (clear_fault) begin
        state_d = ST_SYNC;
        code_d  = FC_NONE;
      end else begin
        state_d = ST_FAULT;
        code_d  = vcode;
      end
    end

    if (!enable) begin
      state_d = ST_IDLE;
      good_d  = '0;
      have_d  = 1'b0;
      code_d  = FC_NONE;
      meas_d  = 1'b0;
      high_d  = high_q;
      low_d   = low_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      good_q  <= '0;
      have_q  <= 1'b0;
      hgood_q <= 1'b0;
      hlen_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      meas_q  <= 1'b0;
      lock_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      have_q  <= have_d;
      hgood_q <= hgood_d;
      hlen_q  <= hlen_d;
      high_q  <= high_d;
      low_q   <= low_d;
      meas_q  <= meas_d;
      lock_q  <= (state_d == ST_LOCKED);
      fault_q <= (state_d == ST_FAULT);
      code_q  <= code_d;
    end
  end

  assign high_cnt   = high_q;
  assign low_cnt    = low_q;
  assign meas_valid = meas_q;
  assign locked     = lock_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule
